// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the MIPS execute stage.
//   - bus widths for data and GPR addresses
//   - R-type funct codes decoded by ex_stage
//   - divider FSM state encoding
package ex_stage_pkg;

    localparam int DATA_BUS     = 32;
    localparam int REG_ADDR_BUS = 5;

    // arithmetic / logic
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    // shifts
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;

    // HI/LO moves
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;

    // multiply / divide
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_divider.sv
// ex_divider: iterative restoring divider, one quotient bit per cycle.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start             a divide with non-zero divisor is presented
//   is_signed         DIV (1) vs DIVU (0)
//   dividend, divisor operands, sampled when leaving IDLE
//   hold              downstream stall; blocks start and the DONE hand-off
//   busy              stall request: IDLE detect or iterating
//   done              result valid (DONE state)
//   quotient          sign-corrected quotient
//   remainder         sign-corrected remainder (sign of dividend)
//
// state | meaning
// IDLE  | waiting for start; operands loaded as magnitudes on exit
// BUSY  | one shift-subtract step per cycle, down-counter to zero
// DONE  | result held until hold is low, then back to IDLE
module ex_divider
    import ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

    div_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
    logic                  quot_neg_q, quot_neg_d;
    logic                  rem_neg_q, rem_neg_d;

    logic                  dvd_neg, dvs_neg;
    logic [DATA_WIDTH-1:0] dvd_mag, dvs_mag;
    logic [DATA_WIDTH:0]   partial;
    logic                  step_ge;
    logic [DATA_WIDTH-1:0] rem_step;

    assign dvd_neg = is_signed & dividend[DATA_WIDTH-1];
    assign dvs_neg = is_signed & divisor[DATA_WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor  : divisor;

    // partial remainder is always < divisor, so partial < 2*divisor and the
    // difference fits back into DATA_WIDTH bits
    assign partial  = {rem_q, quot_q[DATA_WIDTH-1]};
    assign step_ge  = (partial >= {1'b0, dvsr_q});
    assign rem_step = step_ge ? (partial[DATA_WIDTH-1:0] - dvsr_q)
                              : partial[DATA_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        case (state_q)
            DIV_IDLE: begin
                if (start && !hold) begin
                    state_d    = DIV_BUSY;
                    cnt_d      = CNT_LAST;
                    quot_d     = dvd_mag;
                    rem_d      = '0;
                    dvsr_d     = dvs_mag;
                    quot_neg_d = dvd_neg ^ dvs_neg;
                    rem_neg_d  = dvd_neg;
                end
            end
            DIV_BUSY: begin
                quot_d = {quot_q[DATA_WIDTH-2:0], step_ge};
                rem_d  = rem_step;
                if (cnt_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_DONE: begin
                if (!hold) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
        end
    end

    assign busy      = (state_q == DIV_BUSY) || ((state_q == DIV_IDLE) && start);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = quot_neg_q ? -quot_q : quot_q;
    assign remainder = rem_neg_q  ? -rem_q  : rem_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage (ALU, shifter, multiplier, HI/LO, divider).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   hold_in                  downstream stall from the pipeline controller
//   funct_in, shamt_in       R-type decode fields from ID/EX
//   operand_1_in/_2_in       operands A (rs) and B (rt / immediate)
//   reg_write_en_in/_addr_in GPR write control from ID/EX
//   result_out               combinational ALU/shift/MFHI/MFLO result
//   reg_write_en_out/_addr_out GPR write control to EX/MEM
//   stall_request            divider busy
//   overflow_out             signed ADD/SUB overflow
//
// Optional: define EX_OVERFLOW_TRAP_EN to flag signed ADD/SUB overflow and
// suppress the register write; otherwise ADD/SUB wrap like ADDU/SUBU.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BUS,
    parameter int DIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold_in,
    input  logic [5:0]              funct_in,
    input  logic [4:0]              shamt_in,
    input  logic [DATA_WIDTH-1:0]   operand_1_in,
    input  logic [DATA_WIDTH-1:0]   operand_2_in,
    input  logic                    reg_write_en_in,
    input  logic [REG_ADDR_BUS-1:0] reg_write_addr_in,
    output logic [DATA_WIDTH-1:0]   result_out,
    output logic                    reg_write_en_out,
    output logic [REG_ADDR_BUS-1:0] reg_write_addr_out,
    output logic                    stall_request,
    output logic                    overflow_out
);

    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;

    logic [DATA_WIDTH-1:0]   a, b;
    logic [DATA_WIDTH-1:0]   sum_add, diff_sub;
    logic [2*DATA_WIDTH-1:0] prod_s, prod_u;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    wen;
    logic                    ovf;

    logic                    div_start, div_signed;
    logic                    div_busy, div_done, div_idle;
    logic [DATA_WIDTH-1:0]   div_quot, div_rem;

    assign a        = operand_1_in;
    assign b        = operand_2_in;
    assign sum_add  = a + b;
    assign diff_sub = a - b;
    assign prod_s   = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} * {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    assign prod_u   = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

`ifdef EX_OVERFLOW_TRAP_EN
    logic add_ovf, sub_ovf;
    assign add_ovf = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                     (sum_add[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
    assign sub_ovf = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) &&
                     (diff_sub[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
    assign ovf     = ((funct_in == F_ADD) && add_ovf) || ((funct_in == F_SUB) && sub_ovf);
`else
    assign ovf = 1'b0;
`endif

    assign div_signed = (funct_in == F_DIV);
    assign div_start  = ((funct_in == F_DIV) || (funct_in == F_DIVU)) && (b != '0);

    ex_divider #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .is_signed (div_signed),
        .dividend  (a),
        .divisor   (b),
        .hold      (hold_in),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // busy also covers the IDLE-detect cycle, where funct is a divide and no
    // HI/LO move can be present, so this is exact for the writes below
    assign div_idle = !div_busy && !div_done;

    always_comb begin
        alu_res = '0;
        case (funct_in)
            F_ADD, F_ADDU: alu_res = sum_add;
            F_SUB, F_SUBU: alu_res = diff_sub;
            F_AND:         alu_res = a & b;
            F_OR:          alu_res = a | b;
            F_XOR:         alu_res = a ^ b;
            F_NOR:         alu_res = ~(a | b);
            F_SLT:         alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            F_SLTU:        alu_res = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            F_SLL:         alu_res = b << shamt_in;
            F_SRL:         alu_res = b >> shamt_in;
            F_SRA:         alu_res = $unsigned($signed(b) >>> shamt_in);
            F_SLLV:        alu_res = b << a[4:0];
            F_SRLV:        alu_res = b >> a[4:0];
            F_SRAV:        alu_res = $unsigned($signed(b) >>> a[4:0]);
            F_MFHI:        alu_res = hi_q;
            F_MFLO:        alu_res = lo_q;
            default:       alu_res = '0;
        endcase
    end

    always_comb begin
        wen = 1'b0;
        case (funct_in)
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
            F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
            F_MFHI, F_MFLO: wen = reg_write_en_in;
            default:        wen = 1'b0;
        endcase
        if (ovf) begin
            wen = 1'b0;
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_done && !hold_in) begin
            lo_d = div_quot;
            hi_d = div_rem;
        end else if (div_idle && !hold_in) begin
            case (funct_in)
                F_MTHI:  hi_d = a;
                F_MTLO:  lo_d = a;
                F_MULT:  {hi_d, lo_d} = prod_s;
                F_MULTU: {hi_d, lo_d} = prod_u;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // outputs are forced low while reset is held
    assign result_out         = rst ? alu_res : '0;
    assign reg_write_en_out   = rst & wen;
    assign reg_write_addr_out = rst ? reg_write_addr_in : '0;
    assign stall_request      = rst & div_busy;
    assign overflow_out       = rst & ovf;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic        hold_in;
    logic [5:0]  funct_in;
    logic [4:0]  shamt_in;
    logic [31:0] operand_1_in;
    logic [31:0] operand_2_in;
    logic        reg_write_en_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] result_out;
    logic        reg_write_en_out;
    logic [4:0]  reg_write_addr_out;
    logic        stall_request;
    logic        overflow_out;

    int vectors;
    int miscompares;
    int n_stall;

    ex_stage dut (
        .clk                (clk),
        .rst                (rst),
        .hold_in            (hold_in),
        .funct_in           (funct_in),
        .shamt_in           (shamt_in),
        .operand_1_in       (operand_1_in),
        .operand_2_in       (operand_2_in),
        .reg_write_en_in    (reg_write_en_in),
        .reg_write_addr_in  (reg_write_addr_in),
        .result_out         (result_out),
        .reg_write_en_out   (reg_write_en_out),
        .reg_write_addr_out (reg_write_addr_out),
        .stall_request      (stall_request),
        .overflow_out       (overflow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // apply inputs and settle, leaving us well clear of the next edge
    task automatic drive(input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] op1, input logic [31:0] op2,
                         input logic en, input logic [4:0] addr);
        funct_in          = f;
        shamt_in          = sh;
        operand_1_in      = op1;
        operand_2_in      = op2;
        reg_write_en_in   = en;
        reg_write_addr_in = addr;
        #2;
    endtask

    // count consecutive cycles with stall_request high, bounded
    task automatic count_stall(output int n);
        n = 0;
        for (int k = 0; k < 100 && stall_request; k++) begin
            n++;
            @(posedge clk);
            #3;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        hold_in     = 1'b0;
        drive(6'h20, 5'd0, 32'd5, 32'd3, 1'b1, 5'd7);

        // reset state
        chk("rst_result", result_out, 32'h0);
        chk("rst_wen", {31'b0, reg_write_en_out}, 32'h0);
        chk("rst_addr", {27'b0, reg_write_addr_out}, 32'h0);
        chk("rst_stall", {31'b0, stall_request}, 32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        drive(6'h12, 5'd0, 32'h0, 32'h0, 1'b1, 5'd1);
        chk("rst_lo", result_out, 32'h0);

        // ADD overflow
        drive(6'h20, 5'd0, 32'h7FFFFFFF, 32'h00000001, 1'b1, 5'd3);
`ifdef EX_OVERFLOW_TRAP_EN
        chk("add_ovf_flag", {31'b0, overflow_out}, 32'h1);
        chk("add_ovf_wen", {31'b0, reg_write_en_out}, 32'h0);
`else
        chk("add_wrap_res", result_out, 32'h80000000);
        chk("add_wrap_wen", {31'b0, reg_write_en_out}, 32'h1);
        chk("add_wrap_ovf", {31'b0, overflow_out}, 32'h0);
`endif
        chk("add_addr", {27'b0, reg_write_addr_out}, 32'd3);
        drive(6'h23, 5'd0, 32'h0, 32'h1, 1'b1, 5'd4);
        chk("subu", result_out, 32'hFFFFFFFF);
        drive(6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1, 1'b1, 5'd4);
        chk("slt", result_out, 32'h1);
        drive(6'h2B, 5'd0, 32'hFFFFFFFF, 32'h1, 1'b1, 5'd4);
        chk("sltu", result_out, 32'h0);
        drive(6'h24, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd4);
        chk("and", result_out, 32'hF000F000);
        drive(6'h25, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd4);
        chk("or", result_out, 32'hFFF0FFF0);
        drive(6'h26, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd4);
        chk("xor", result_out, 32'h0FF00FF0);
        drive(6'h27, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4);
        chk("nor", result_out, 32'hFFFFFFFF);
        drive(6'h3F, 5'd0, 32'h12345678, 32'h1, 1'b1, 5'd4);
        chk("unk_res", result_out, 32'h0);
        chk("unk_wen", {31'b0, reg_write_en_out}, 32'h0);

        // shifts
        drive(6'h03, 5'd4, 32'h0, 32'hF0000000, 1'b1, 5'd5);
        chk("sra", result_out, 32'hFF000000);
        drive(6'h07, 5'd0, 32'h00000024, 32'h80000000, 1'b1, 5'd5);
        chk("srav", result_out, 32'hF8000000);
        drive(6'h06, 5'd0, 32'h00000004, 32'h80000000, 1'b1, 5'd5);
        chk("srlv", result_out, 32'h08000000);
        drive(6'h00, 5'd8, 32'h0, 32'h00000001, 1'b1, 5'd5);
        chk("sll", result_out, 32'h00000100);

        // MULT signed, then MULTU
        drive(6'h18, 5'd0, 32'hFFFFFFFE, 32'h00000003, 1'b1, 5'd6);
        chk("mult_wen", {31'b0, reg_write_en_out}, 32'h0);
        next_cycle();
        drive(6'h10, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6);
        chk("mult_hi", result_out, 32'hFFFFFFFF);
        drive(6'h12, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6);
        chk("mult_lo", result_out, 32'hFFFFFFFA);
        drive(6'h19, 5'd0, 32'hFFFFFFFF, 32'h00000002, 1'b1, 5'd6);
        next_cycle();
        drive(6'h10, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6);
        chk("multu_hi", result_out, 32'h00000001);
        drive(6'h12, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6);
        chk("multu_lo", result_out, 32'hFFFFFFFE);

        // signed DIV -7/2
        drive(6'h1A, 5'd0, 32'hFFFFFFF9, 32'h00000002, 1'b1, 5'd8);
        chk("div_wen", {31'b0, reg_write_en_out}, 32'h0);
        count_stall(n_stall);
        chk("div_stall_cycles", n_stall, 32'd33);
        next_cycle();
        drive(6'h12, 5'd0, 32'h0, 32'h0, 1'b1, 5'd8);
        chk("div_lo", result_out, 32'hFFFFFFFD);
        chk("div_after_stall", {31'b0, stall_request}, 32'h0);
        drive(6'h10, 5'd0, 32'h0, 32'h0, 1'b1, 5'd8);
        chk("div_hi", result_out, 32'hFFFFFFFF);

        // DIVU 64/7
        drive(6'h1B, 5'd0, 32'd64, 32'd7, 1'b1, 5'd8);
        count_stall(n_stall);
        chk("divu_stall_cycles", n_stall, 32'd33);
        next_cycle();
        drive(6'h12, 5'd0, 32'h0, 32'h0, 1'b1, 5'd8);
        chk("divu_lo", result_out, 32'd9);
        drive(6'h10, 5'd0, 32'h0, 32'h0, 1'b1, 5'd8);
        chk("divu_hi", result_out, 32'd1);

        // divide by zero leaves HI/LO alone
        drive(6'h11, 5'd0, 32'hAAAAAAAA, 32'h0, 1'b0, 5'd0);
        next_cycle();
        drive(6'h13, 5'd0, 32'h55555555, 32'h0, 1'b0, 5'd0);
        next_cycle();
        drive(6'h1A, 5'd0, 32'd100, 32'h0, 1'b0, 5'd0);
        chk("div0_stall_a", {31'b0, stall_request}, 32'h0);
        next_cycle();
        #2;
        chk("div0_stall_b", {31'b0, stall_request}, 32'h0);
        next_cycle();
        drive(6'h10, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0);
        chk("div0_hi", result_out, 32'hAAAAAAAA);
        drive(6'h12, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0);
        chk("div0_lo", result_out, 32'h55555555);

        // DONE held by hold_in for 3 cycles
        drive(6'h1B, 5'd0, 32'd100, 32'd7, 1'b0, 5'd0);
        count_stall(n_stall);
        chk("hold_stall_cycles", n_stall, 32'd33);
        hold_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(6'h12, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0);
            chk("hold_no_write", result_out, 32'h55555555);
            chk("hold_no_restart", {31'b0, stall_request}, 32'h0);
        end
        funct_in     = 6'h1B;
        operand_1_in = 32'd100;
        operand_2_in = 32'd7;
        hold_in      = 1'b0;
        next_cycle();
        drive(6'h12, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0);
        chk("hold_lo", result_out, 32'd14);
        chk("hold_release_stall", {31'b0, stall_request}, 32'h0);
        drive(6'h10, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0);
        chk("hold_hi", result_out, 32'd2);

        // reset in the middle of a divide
        drive(6'h1A, 5'd0, 32'd100, 32'd3, 1'b0, 5'd0);
        for (int k = 0; k < 10; k++) begin
            next_cycle();
        end
        chk("mid_div_stall", {31'b0, stall_request}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_abort_stall", {31'b0, stall_request}, 32'h0);
        drive(6'h10, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0);
        next_cycle();
        rst = 1'b1;
        #2;
        chk("post_rst_hi", result_out, 32'h0);
        chk("post_rst_stall", {31'b0, stall_request}, 32'h0);
        drive(6'h12, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0);
        chk("post_rst_lo", result_out, 32'h0);
        drive(6'h13, 5'd0, 32'h12345678, 32'h0, 1'b0, 5'd0);
        next_cycle();
        drive(6'h12, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9);
        chk("mtlo_mflo", result_out, 32'h12345678);
        chk("mflo_wen", {31'b0, reg_write_en_out}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the ID/EX pipeline register and feeds the EX/MEM register.
- Decodes the R-type funct field and produces the ALU and shifter result.
- Owns the architectural HI/LO registers.
- Runs an iterative multi-cycle divider and raises a stall request to the pipeline controller while a divide is in flight.

Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- DIV_CYCLES, 32, number of divider iteration cycles; must equal DATA_WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hold_in  in  1  EX stage stalled by the pipeline controller (MEM/downstream stall).
- funct_in  in  6  funct field from ID/EX.
- shamt_in  in  5  shift amount from ID/EX.
- operand_1_in  in  32  rs value / ALU operand A.
- operand_2_in  in  32  rt value or immediate / ALU operand B.
- reg_write_en_in  in  1  GPR write enable from ID/EX.
- reg_write_addr_in  in  5  GPR destination from ID/EX.
- result_out  out  32  ALU/shift/MFHI/MFLO result.
- reg_write_en_out  out  1  GPR write enable to EX/MEM.
- reg_write_addr_out  out  5  passthrough of reg_write_addr_in.
- stall_request  out  1  divider busy; controller stalls PC, IF/ID and ID/EX.
- overflow_out  out  1  signed overflow flag (see Optional Feature).

Behaviour:
- Reset while rst is low: all outputs are 0, HI=LO=0, FSM in IDLE. A reset mid-divide aborts the divide; HI/LO stay 0.
- result_out is combinational from the inputs and HI/LO; zero added latency.
- Funct encoding (hex):
  - Arithmetic/logic: ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B.
  - Shifts: SLL 00, SRL 02, SRA 03, SLLV 04, SRLV 06, SRAV 07. Variable shifts use operand_1[4:0]; fixed shifts use shamt_in. The shifted value is operand_2.
  - HI/LO moves: MFHI 10, MTHI 11, MFLO 12, MTLO 13.
  - Multiply/divide: MULT 18, MULTU 19, DIV 1A, DIVU 1B.
- Any other funct gives result_out=0 and reg_write_en_out=0.
- Add/subtract wrap modulo 2^32. SLT is a signed compare; SLTU is an unsigned compare; both yield 0 or 1.
- HI/LO writes occur on the rising edge, only when hold_in=0 and the FSM is IDLE.
  - MTHI/MTLO write operand_1.
  - MULT/MULTU write the 64-bit product in one cycle: HI = product[63:32], LO = product[31:0].
- MFHI/MFLO read the registered HI/LO. A move-to followed by a move-from in the next instruction sees the new value.
- Divider FSM:
  - IDLE:
    - DIV/DIVU present and divisor != 0: stall_request=1 combinationally. Load magnitudes and record signs (signed only). Go to BUSY with counter=0.
    - Divisor == 0: no stall, HI/LO unchanged, stay in IDLE.
  - BUSY: one restoring shift-subtract step per cycle; stall_request=1. When counter=DIV_CYCLES-1, go to DONE.
  - DONE:
    - stall_request=0.
    - Quotient is negated if the operand signs differ; remainder takes the dividend's sign.
    - On the edge where hold_in=0: LO=quotient, HI=remainder, go to IDLE.
    - If hold_in=1: stay in DONE, do not write.
  - Total stall: 33 cycles (IDLE detect + 32 BUSY). The DONE state guarantees the held divide instruction is not restarted.
- MULT/DIV, MTHI/MTLO and unknown funct force reg_write_en_out=0. Other valid functs pass reg_write_en_in through.
- hold_in high with the FSM IDLE suppresses the start of a divide until hold_in falls.

Optional Feature:
- Macro EX_OVERFLOW_TRAP_EN.
- Defined:
  - ADD/SUB signed overflow sets overflow_out=1 combinationally.
  - reg_write_en_out is forced to 0 for that instruction.
- Undefined: overflow_out is tied to 0 and ADD behaves as ADDU (SUB as SUBU).

Decomposition:
- Shared package/include: funct code constants, DATA_BUS/REG_ADDR_BUS widths, divider FSM state encoding (IDLE/BUSY/DONE).
- One sub-module, ex_divider: FSM, counter, partial remainder and sign fix-up. Handshake: start, signed, dividend, divisor, hold → busy, done, quotient, remainder.
- The ALU, shifter, multiplier and HI/LO registers stay in ex_stage.

Test Plan:
1. ADD 7FFFFFFF+00000001, en_in=1 → with macro: overflow_out=1, reg_write_en_out=0. Without macro: result 80000000, reg_write_en_out=1.
2. SRA shamt=4, op2=F0000000 → result FF000000. SRAV op1=0000_0024, op2=80000000 → result F8000000 (shift 4).
3. MULT op1=FFFFFFFE (-2), op2=00000003, hold=0 → next cycle MFHI returns FFFFFFFF and MFLO returns FFFFFFFA.
4. DIV op1=FFFFFFF9 (-7), op2=00000002 → stall_request high exactly 33 cycles, then LO=FFFFFFFD (-3), HI=FFFFFFFF (-1). DIVU 64/7 → LO=9, HI=1.
5. DIV with divisor 0 → stall_request never asserts, HI/LO unchanged. DIV reaching DONE with hold_in=1 for 3 cycles → no HI/LO write until hold_in falls, no restart.
6. rst asserted 10 cycles into a divide → stall_request=0 immediately, HI=LO=0, FSM IDLE. After release, MTLO 12345678 then MFLO → 12345678.
